// File: rtl/mr1_dbus_responder.sv
// MR1 dBus memory responder: word RAM with byte-lane writes and fixed-latency, in-order reads.
// Reads respond RSP_LATENCY cycles after accept with no back-pressure; cmd_ready drops while MAX_PENDING reads are outstanding.
module mr1_dbus_responder #(
  parameter int MEM_WORDS   = 1024,
  parameter int RSP_LATENCY = 2,
  parameter int MAX_PENDING = 4,
  localparam int PW = $clog2(MAX_PENDING + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          dBus_cmd_valid,
  output logic          dBus_cmd_ready,
  input  logic          dBus_cmd_payload_wr,
  input  logic [31:0]   dBus_cmd_payload_address,
  input  logic [31:0]   dBus_cmd_payload_data,
  input  logic [1:0]    dBus_cmd_payload_size,
  output logic          dBus_rsp_ready,
  output logic [31:0]   dBus_rsp_data,
  output logic          dBus_rsp_error,
  output logic          write_error,
  output logic [PW-1:0] pending
);
  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int QW = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
  localparam bit BYPASS = (RSP_LATENCY == 1);
  localparam logic [2:0] POP_AGE = 3'((RSP_LATENCY > 1) ? RSP_LATENCY - 2 : 0);

  logic [31:0]   mem    [MEM_WORDS];
  logic [31:0]   q_data [MAX_PENDING];
  logic          q_err  [MAX_PENDING];
  logic [2:0]    q_age  [MAX_PENDING];
  logic [QW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] q_cnt;

  logic [29:0]   word_addr;
  logic [AW-1:0] word_idx;
  logic [3:0]    lane;
  logic [31:0]   rd_word;
  logic          illegal, accept, acc_rd, acc_wr, bad_wr, push, pop;
  logic          nxt_vld, nxt_err;
  logic [31:0]   nxt_dat;

  function automatic logic [QW-1:0] ptr_inc(input logic [QW-1:0] p);
    return (p == QW'(MAX_PENDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign word_addr      = dBus_cmd_payload_address[31:2];
  assign word_idx       = word_addr[AW-1:0];
  assign dBus_cmd_ready = !reset && (pending < PW'(MAX_PENDING));
  assign accept         = dBus_cmd_valid && dBus_cmd_ready;
  assign acc_rd         = accept && !dBus_cmd_payload_wr;
  assign acc_wr         = accept && dBus_cmd_payload_wr && !illegal;
  assign bad_wr         = accept && dBus_cmd_payload_wr && illegal;
  assign rd_word        = illegal ? 32'd0 : mem[word_idx];

  always_comb begin
    illegal = (word_addr >= 30'(MEM_WORDS));
    lane    = 4'b0000;
    case (dBus_cmd_payload_size)
      2'd0: lane = 4'b0001 << dBus_cmd_payload_address[1:0];
      2'd1: begin
        lane    = dBus_cmd_payload_address[1] ? 4'b1100 : 4'b0011;
        illegal = illegal | dBus_cmd_payload_address[0];
      end
      2'd2: begin
        lane    = 4'b1111;
        illegal = illegal | (dBus_cmd_payload_address[1:0] != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

  // With a latency of one the sampled word goes straight to the response registers.
  assign push = acc_rd && !BYPASS;
  assign pop  = !BYPASS && (q_cnt != '0) && (q_age[rd_ptr] == POP_AGE);

  always_comb begin
    nxt_vld = 1'b0;
    nxt_dat = 32'd0;
    nxt_err = 1'b0;
    if (BYPASS) begin
      nxt_vld = acc_rd;
      nxt_dat = acc_rd ? rd_word : 32'd0;
      nxt_err = acc_rd && illegal;
    end else begin
      nxt_vld = pop;
      nxt_dat = pop ? q_data[rd_ptr] : 32'd0;
      nxt_err = pop && q_err[rd_ptr];
    end
  end

  always_ff @(posedge clock) begin
    if (acc_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (lane[b]) mem[word_idx][8*b +: 8] <= dBus_cmd_payload_data[8*b +: 8];
      end
    end
  end

  // Ages advance every cycle; stale slots are never read because q_cnt gates the head.
  always_ff @(posedge clock) begin
    for (int i = 0; i < MAX_PENDING; i++) q_age[i] <= q_age[i] + 3'd1;
    if (push) begin
      q_data[wr_ptr] <= rd_word;
      q_err[wr_ptr]  <= illegal;
      q_age[wr_ptr]  <= 3'd0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      q_cnt          <= '0;
      pending        <= '0;
      write_error    <= 1'b0;
      dBus_rsp_ready <= 1'b0;
      dBus_rsp_data  <= 32'd0;
      dBus_rsp_error <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      q_cnt   <= q_cnt + PW'(push) - PW'(pop);
      pending <= pending + PW'(acc_rd) - PW'(dBus_rsp_ready);
      if (bad_wr) write_error <= 1'b1;
      dBus_rsp_ready <= nxt_vld;
      dBus_rsp_data  <= nxt_dat;
      dBus_rsp_error <= nxt_err;
    end
  end
endmodule

// File: doc/mr1_dbus_responder.md
# mr1_dbus_responder

Memory-side responder for the MR1 data bus: accepts `dBus` commands from the core, commits writes to a local word-addressed RAM and returns read data after a fixed latency. Lets benches and FPGA builds drive MR1's `dBus` without an external memory model. Has bounded outstanding reads and deterministic response timing, so `dBus_rsp_ready` always arrives within the fairness window that the formal flow enforces.

## Interface
- `MEM_WORDS`, 1024: RAM depth in 32-bit words; power of two.
- `RSP_LATENCY`, 2: cycles from read accept to response; legal range 1..8.
- `MAX_PENDING`, 4: maximum reads accepted but not yet responded; must be at least 1.
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `dBus_cmd_valid`  in  1  command present.
- `dBus_cmd_ready`  out  1  command accepted this cycle when high together with valid.
- `dBus_cmd_payload_wr`  in  1  1 = write, 0 = read.
- `dBus_cmd_payload_address`  in  32  byte address.
- `dBus_cmd_payload_data`  in  32  write data, already lane-replicated by the initiator.
- `dBus_cmd_payload_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- `dBus_rsp_ready`  out  1  one-cycle read-response strobe.
- `dBus_rsp_data`  out  32  aligned read word.
- `dBus_rsp_error`  out  1  read response carries an error.
- `write_error`  out  1  sticky flag: an illegal write was discarded.
- `pending`  out  clog2(MAX_PENDING+1)  count of outstanding reads.

## Operation
- Accept: `dBus_cmd_ready` = !reset && pending < MAX_PENDING; combinational from the registered count. The same rule applies to reads and writes.
- Legality: a command is illegal if any of the following holds: size == 3; size 1 with addr[0] set; size 2 with addr[1:0] != 0; or addr[31:2] >= MEM_WORDS.
- Legal write: commits at the accept edge.
  - Lane mask: size 0 writes byte addr[1:0]; size 1 writes half addr[1]; size 2 writes all 4 bytes.
  - Each written byte lane takes the same lane of the payload data; no shifting.
  - Writes produce no response and do not touch `pending`.
- Illegal write: discarded with RAM unchanged; sets `write_error`, which clears only on reset.
- Read: at the accept edge, the RAM word at addr[31:2] is sampled into a pending entry together with the error bit and an age counter.
  - An illegal read sets its entry's error bit and stores data 0.
  - Because the sample is taken at accept, read-after-write on consecutive cycles returns the new data.
- Pending queue: in-order FIFO of MAX_PENDING entries. All entries share one latency, so responses stay in order, at most one per cycle.
- Response: `dBus_rsp_ready`, `dBus_rsp_data` and `dBus_rsp_error` are registered outputs.
  - The head entry drives them for exactly one cycle.
  - There is no back-pressure; the initiator must take the response.
  - Data is the full aligned word; the initiator extracts the byte or half.
  - When `dBus_rsp_ready` = 0, data and error are 0.
- Pending count: +1 on read accept, −1 at the end of the response cycle; both in one cycle leaves it unchanged.
- Reset: asynchronous; may assert at any time.
  - Flushes the queue and zeroes `pending`, `dBus_rsp_ready`, `dBus_rsp_data`, `dBus_rsp_error` and `write_error`.
  - `dBus_cmd_ready` reads 0 while reset is high.
  - RAM contents are not cleared.
  - Reads in flight when reset asserts never respond.

## Timing
- Read accepted at edge N → `dBus_rsp_ready` high during cycle N+RSP_LATENCY. That entry counts in `pending` for cycles N+1 .. N+RSP_LATENCY.
- Full read throughput (one per cycle) requires MAX_PENDING ≥ RSP_LATENCY+1. Smaller values stall `dBus_cmd_ready` periodically, but the worst-case command wait stays below RSP_LATENCY+1 cycles.
- A write accepted at edge N is visible to a read accepted at edge N+1.
- First command can be accepted in the first cycle after reset deasserts.

## Test plan
- Write 0xDEADBEEF to 0x10 (size 2), then read 0x10 with RSP_LATENCY=2 → read accepted at N; rsp_ready high only in N+2 with data 0xDEADBEEF, error 0.
- Next, byte write size 0 to 0x11 with data 0x5A5A5A5A, then read 0x10 → data 0xDEAD5AEF. Then a half write size 1 to 0x12 with data 0x12341234 and read → 0x12345AEF.
- MAX_PENDING=2, RSP_LATENCY=2, reads to 0x0 held valid for 6 cycles → accepts at N, N+1, N+3, N+4 …; ready low in N+2 and N+5; `pending` never exceeds 2; responses at N+2, N+3, N+5, N+6.
- Illegal commands:
  - Read at MEM_WORDS*4 → response with error 1, data 0.
  - Write size 2 to 0x2 → write_error rises, RAM word 0 unchanged.
  - Read size 3 → error response.
- Reset pulse one cycle after a read accept (latency 2) → no rsp_ready ever appears; `pending` = 0; outputs 0; a following read of the same address returns the pre-reset RAM data.
- Random command stream with MAX_PENDING=4, RSP_LATENCY=3 against a scoreboard model → every read responds exactly 3 cycles after accept, in order, with matching data; `pending` ≤ 4 throughout.
